// File: rtl/shot_sequencer_if.sv
// Bus between the shot sequencer and the path block / player keys.
// The slave modport is the sequencer side; the master modport is the
// path/keys side. The swap key exists only when COLOR_SWAP_EN is defined.
interface shot_sequencer_if;
  logic       frame_clk;
  logic       start;
  logic       fire;
`ifdef COLOR_SWAP_EN
  logic       swap;
`endif
  logic [9:0] Shooter_X;
  logic       dead;
  logic       win;
  logic       inserted;
  logic [1:0] Game_State;
  logic [9:0] Shot_X;
  logic [9:0] Shot_Y;
  logic [3:0] Cur_Color;
  logic [3:0] Next_Color;
  logic [1:0] random_color;
  logic       shot_active;
  logic [7:0] Shots_Fired;

`ifdef COLOR_SWAP_EN
  modport master (
    output frame_clk, start, fire, swap, Shooter_X, dead, win, inserted,
    input  Game_State, Shot_X, Shot_Y, Cur_Color, Next_Color,
           random_color, shot_active, Shots_Fired
  );
  modport slave (
    input  frame_clk, start, fire, swap, Shooter_X, dead, win, inserted,
    output Game_State, Shot_X, Shot_Y, Cur_Color, Next_Color,
           random_color, shot_active, Shots_Fired
  );
`else
  modport master (
    output frame_clk, start, fire, Shooter_X, dead, win, inserted,
    input  Game_State, Shot_X, Shot_Y, Cur_Color, Next_Color,
           random_color, shot_active, Shots_Fired
  );
  modport slave (
    input  frame_clk, start, fire, Shooter_X, dead, win, inserted,
    output Game_State, Shot_X, Shot_Y, Cur_Color, Next_Color,
           random_color, shot_active, Shots_Fired
  );
`endif
endinterface

// File: rtl/shot_sequencer.sv
// Game and shot controller feeding the path block: owns the game state,
// launches/flies/retires the single shooter ball and supplies ball colours
// plus an LFSR random colour for path spawns.
// Optional feature macro: COLOR_SWAP_EN (swap key exchanges Cur/Next colour).
module shot_sequencer #(
  parameter logic [9:0]  SHOT_Y0    = 10'd440,
  parameter logic [9:0]  SHOT_Y_MIN = 10'd16,
  parameter logic [9:0]  SHOT_SPEED = 10'd8,
  parameter logic [9:0]  PARK_XY    = 10'd1000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic Clk,
  input logic Reset,
  shot_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_PLAY = 2'd1,
    GS_OVER = 2'd2,
    GS_WON  = 2'd3
  } gameState_t;

  typedef enum logic [1:0] {
    SH_LOADED,
    SH_FLYING,
    SH_RETIRE,
    SH_WAIT_CLEAR
  } shotState_t;

  // Below this Y the next step would cross the top boundary, so it is a miss.
  localparam logic [9:0] MISS_LIMIT = SHOT_Y_MIN + SHOT_SPEED;

  gameState_t  gameState_q, gameState_d;
  shotState_t  shotState_q, shotState_d;
  logic [9:0]  shotX_q, shotX_d;
  logic [9:0]  shotY_q, shotY_d;
  logic [3:0]  curColor_q, curColor_d;
  logic [3:0]  nextColor_q, nextColor_d;
  logic        shotActive_q, shotActive_d;
  logic [7:0]  shotsFired_q, shotsFired_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        startPrev_q, firePrev_q;
  logic        startEdge, fireEdge;
`ifdef COLOR_SWAP_EN
  logic        swapPrev_q;
  logic        swapEdge;
`endif

  assign startEdge = bus.start & ~startPrev_q;
  assign fireEdge  = bus.fire & ~firePrev_q;
`ifdef COLOR_SWAP_EN
  assign swapEdge  = bus.swap & ~swapPrev_q;
`endif

  // Register all state and outputs; synchronous reset restores the idle game.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      gameState_q  <= GS_IDLE;
      shotState_q  <= SH_LOADED;
      shotX_q      <= PARK_XY;
      shotY_q      <= PARK_XY;
      curColor_q   <= 4'd1;
      nextColor_q  <= 4'd2;
      shotActive_q <= 1'b0;
      shotsFired_q <= 8'd0;
      lfsr_q       <= LFSR_SEED;
      startPrev_q  <= 1'b0;
      firePrev_q   <= 1'b0;
`ifdef COLOR_SWAP_EN
      swapPrev_q   <= 1'b0;
`endif
    end else begin
      gameState_q  <= gameState_d;
      shotState_q  <= shotState_d;
      shotX_q      <= shotX_d;
      shotY_q      <= shotY_d;
      curColor_q   <= curColor_d;
      nextColor_q  <= nextColor_d;
      shotActive_q <= shotActive_d;
      shotsFired_q <= shotsFired_d;
      lfsr_q       <= lfsr_d;
      startPrev_q  <= bus.start;
      firePrev_q   <= bus.fire;
`ifdef COLOR_SWAP_EN
      swapPrev_q   <= bus.swap;
`endif
    end
  end

  // Next-state logic for the game FSM, the shot FSM and the free-running LFSR.
  always_comb begin
    gameState_d  = gameState_q;
    shotState_d  = shotState_q;
    shotX_d      = shotX_q;
    shotY_d      = shotY_q;
    curColor_d   = curColor_q;
    nextColor_d  = nextColor_q;
    shotsFired_d = shotsFired_q;
    lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    case (gameState_q)
      GS_IDLE: if (startEdge) gameState_d = GS_PLAY;
      GS_PLAY: begin
        if (bus.dead)     gameState_d = GS_OVER;
        else if (bus.win) gameState_d = GS_WON;
      end
      GS_OVER, GS_WON: if (startEdge) gameState_d = GS_IDLE;
      default: gameState_d = GS_IDLE;
    endcase

    if (gameState_d != GS_PLAY) begin
      shotState_d = SH_LOADED;
      shotX_d     = PARK_XY;
      shotY_d     = PARK_XY;
    end else if (gameState_q != GS_PLAY) begin
      shotState_d  = SH_LOADED;
      shotX_d      = PARK_XY;
      shotY_d      = PARK_XY;
      curColor_d   = {2'b00, lfsr_q[1:0]} + 4'd1;
      nextColor_d  = {2'b00, lfsr_q[3:2]} + 4'd1;
      shotsFired_d = 8'd0;
    end else begin
      case (shotState_q)
        SH_LOADED: begin
          if (fireEdge) begin
            shotX_d     = bus.Shooter_X;
            shotY_d     = SHOT_Y0;
            shotState_d = SH_FLYING;
            if (shotsFired_q != 8'hFF) shotsFired_d = shotsFired_q + 8'd1;
          end
`ifdef COLOR_SWAP_EN
          if (swapEdge) begin
            curColor_d  = nextColor_q;
            nextColor_d = curColor_q;
          end
`endif
        end
        SH_FLYING: begin
          if (bus.inserted) begin
            shotState_d = SH_RETIRE;
          end else if (bus.frame_clk) begin
            if (shotY_q < MISS_LIMIT) shotState_d = SH_RETIRE;
            else                      shotY_d     = shotY_q - SHOT_SPEED;
          end
        end
        SH_RETIRE: begin
          shotX_d     = PARK_XY;
          shotY_d     = PARK_XY;
          curColor_d  = nextColor_q;
          nextColor_d = {2'b00, lfsr_q[1:0]} + 4'd1;
          shotState_d = SH_WAIT_CLEAR;
        end
        SH_WAIT_CLEAR: if (!bus.inserted) shotState_d = SH_LOADED;
        default: shotState_d = SH_LOADED;
      endcase
    end

    shotActive_d = (shotState_d == SH_FLYING);
  end

  assign bus.Game_State   = gameState_q;
  assign bus.Shot_X       = shotX_q;
  assign bus.Shot_Y       = shotY_q;
  assign bus.Cur_Color    = curColor_q;
  assign bus.Next_Color   = nextColor_q;
  assign bus.random_color = lfsr_q[1:0];
  assign bus.shot_active  = shotActive_q;
  assign bus.Shots_Fired  = shotsFired_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Directed self-checking bench for shot_sequencer: reset, start, flight,
// hit with a long inserted pulse, miss at the top boundary, dead/win,
// shot-count saturation and (with COLOR_SWAP_EN) colour swapping.
module tb_shot_sequencer;

  logic Clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] lfsrModel;
  logic [15:0] snap;
  logic [3:0]  curBefore, nextBefore, expColor;

  shot_sequencer_if busIf ();

  shot_sequencer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (busIf)
  );

  // 50 MHz clock.
  always #10 Clk = ~Clk;

  // Reference LFSR: taps 16,14,13,11 of a right-shifting Fibonacci register.
  always @(posedge Clk) begin
    if (Reset) lfsrModel <= 16'hACE1;
    else       lfsrModel <= {^(lfsrModel & 16'h002D), lfsrModel[15:1]};
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic stepClock(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic framePulse();
    busIf.frame_clk = 1'b1;
    stepClock(1);
    busIf.frame_clk = 1'b0;
    stepClock(1);
  endtask

  task automatic pressStart();
    busIf.start = 1'b1;
    stepClock(1);
    busIf.start = 1'b0;
  endtask

  initial begin
    Reset           = 1'b1;
    busIf.frame_clk = 1'b0;
    busIf.start     = 1'b0;
    busIf.fire      = 1'b0;
`ifdef COLOR_SWAP_EN
    busIf.swap      = 1'b0;
`endif
    busIf.Shooter_X = 10'd0;
    busIf.dead      = 1'b0;
    busIf.win       = 1'b0;
    busIf.inserted  = 1'b0;
    stepClock(2);

    checkOutput("rst_state",  16'(busIf.Game_State),   16'd0);
    checkOutput("rst_x",      16'(busIf.Shot_X),       16'd1000);
    checkOutput("rst_y",      16'(busIf.Shot_Y),       16'd1000);
    checkOutput("rst_cur",    16'(busIf.Cur_Color),    16'd1);
    checkOutput("rst_next",   16'(busIf.Next_Color),   16'd2);
    checkOutput("rst_active", 16'(busIf.shot_active),  16'd0);
    checkOutput("rst_fired",  16'(busIf.Shots_Fired),  16'd0);
    checkOutput("rst_rand",   16'(busIf.random_color), 16'd1);

    // ACE1 shifts to 5670 on the first free-running edge.
    Reset = 1'b0;
    stepClock(1);
    checkOutput("rand_shift1", 16'(busIf.random_color), 16'd0);

    // Start: colours drawn from the LFSR value of the transition cycle.
    stepClock(3);
    snap = lfsrModel;
    pressStart();
    checkOutput("start_state", 16'(busIf.Game_State),  16'd1);
    expColor = {2'b00, snap[1:0]} + 4'd1;
    checkOutput("start_cur",   16'(busIf.Cur_Color),   16'(expColor));
    expColor = {2'b00, snap[3:2]} + 4'd1;
    checkOutput("start_next",  16'(busIf.Next_Color),  16'(expColor));
    checkOutput("start_fired", 16'(busIf.Shots_Fired), 16'd0);
    checkOutput("start_x",     16'(busIf.Shot_X),      16'd1000);
    checkOutput("start_y",     16'(busIf.Shot_Y),      16'd1000);

    // Fire from X=300, then three frames of flight.
    busIf.Shooter_X = 10'd300;
    busIf.fire = 1'b1;
    stepClock(1);
    busIf.fire = 1'b0;
    checkOutput("fire_x",      16'(busIf.Shot_X),      16'd300);
    checkOutput("fire_y",      16'(busIf.Shot_Y),      16'd440);
    checkOutput("fire_active", 16'(busIf.shot_active), 16'd1);
    checkOutput("fire_count",  16'(busIf.Shots_Fired), 16'd1);
    repeat (3) framePulse();
    checkOutput("fly_y3", 16'(busIf.Shot_Y), 16'd416);

    // Hit with inserted held five cycles and a fire edge inside it.
    curBefore  = busIf.Cur_Color;
    nextBefore = busIf.Next_Color;
    busIf.inserted = 1'b1;
    stepClock(1);
    checkOutput("hit_active", 16'(busIf.shot_active), 16'd0);
    snap = lfsrModel;
    stepClock(1);
    checkOutput("hit_cur",  16'(busIf.Cur_Color), 16'(nextBefore));
    expColor = {2'b00, snap[1:0]} + 4'd1;
    checkOutput("hit_next", 16'(busIf.Next_Color), 16'(expColor));
    checkOutput("hit_park", 16'(busIf.Shot_X), 16'd1000);
    busIf.fire = 1'b1;
    stepClock(1);
    busIf.fire = 1'b0;
    stepClock(2);
    busIf.inserted = 1'b0;
    stepClock(2);
    checkOutput("hit_once_cur",  16'(busIf.Cur_Color),   16'(nextBefore));
    checkOutput("hit_once_next", 16'(busIf.Next_Color),  16'(expColor));
    checkOutput("hit_nofire",    16'(busIf.shot_active), 16'd0);
    checkOutput("hit_nofire_y",  16'(busIf.Shot_Y),      16'd1000);
    checkOutput("hit_count",     16'(busIf.Shots_Fired), 16'd1);

`ifdef COLOR_SWAP_EN
    curBefore  = busIf.Cur_Color;
    nextBefore = busIf.Next_Color;
    busIf.swap = 1'b1;
    stepClock(1);
    busIf.swap = 1'b0;
    checkOutput("swap_cur",  16'(busIf.Cur_Color),  16'(nextBefore));
    checkOutput("swap_next", 16'(busIf.Next_Color), 16'(curBefore));
    stepClock(1);
`endif

    // Miss: 52 frames bring 440 down to 24, one more to 16, then retire.
    busIf.Shooter_X = 10'd123;
    busIf.fire = 1'b1;
    stepClock(1);
    busIf.fire = 1'b0;
    checkOutput("miss_x",     16'(busIf.Shot_X),      16'd123);
    checkOutput("miss_count", 16'(busIf.Shots_Fired), 16'd2);
`ifdef COLOR_SWAP_EN
    curBefore  = busIf.Cur_Color;
    nextBefore = busIf.Next_Color;
    busIf.swap = 1'b1;
    stepClock(1);
    busIf.swap = 1'b0;
    stepClock(1);
    checkOutput("swapfly_cur",  16'(busIf.Cur_Color),  16'(curBefore));
    checkOutput("swapfly_next", 16'(busIf.Next_Color), 16'(nextBefore));
`endif
    repeat (52) framePulse();
    checkOutput("miss_y24", 16'(busIf.Shot_Y), 16'd24);
    framePulse();
    checkOutput("miss_y16",    16'(busIf.Shot_Y),      16'd16);
    checkOutput("miss_fly16",  16'(busIf.shot_active), 16'd1);
    busIf.frame_clk = 1'b1;
    stepClock(1);
    busIf.frame_clk = 1'b0;
    checkOutput("miss_drop",   16'(busIf.shot_active), 16'd0);
    checkOutput("miss_nowrap", 16'(busIf.Shot_Y),      16'd16);
    stepClock(1);
    checkOutput("miss_park",   16'(busIf.Shot_Y),      16'd1000);
    stepClock(1);

    // dead and win together while flying: dead wins, ball parks at once.
    busIf.fire = 1'b1;
    stepClock(1);
    busIf.fire = 1'b0;
    checkOutput("dw_fly", 16'(busIf.shot_active), 16'd1);
    busIf.dead = 1'b1;
    busIf.win  = 1'b1;
    stepClock(1);
    busIf.dead = 1'b0;
    busIf.win  = 1'b0;
    checkOutput("dw_state",  16'(busIf.Game_State),  16'd2);
    checkOutput("dw_park_x", 16'(busIf.Shot_X),      16'd1000);
    checkOutput("dw_park_y", 16'(busIf.Shot_Y),      16'd1000);
    checkOutput("dw_active", 16'(busIf.shot_active), 16'd0);
    stepClock(1);
    pressStart();
    checkOutput("over_idle", 16'(busIf.Game_State), 16'd0);
    stepClock(1);

    // New game: counter clears, then saturates at 255 after 260 shots.
    pressStart();
    checkOutput("replay_state", 16'(busIf.Game_State),  16'd1);
    checkOutput("replay_count", 16'(busIf.Shots_Fired), 16'd0);
    stepClock(1);
    for (int i = 0; i < 260; i++) begin
      busIf.fire = 1'b1;
      stepClock(1);
      busIf.fire = 1'b0;
      busIf.inserted = 1'b1;
      stepClock(1);
      busIf.inserted = 1'b0;
      stepClock(2);
    end
    checkOutput("sat_count", 16'(busIf.Shots_Fired), 16'd255);

    busIf.win = 1'b1;
    stepClock(1);
    busIf.win = 1'b0;
    checkOutput("won_state", 16'(busIf.Game_State), 16'd3);
    stepClock(1);
    pressStart();
    checkOutput("won_idle",  16'(busIf.Game_State), 16'd0);
    checkOutput("rand_model", 16'(busIf.random_color), 16'(lfsrModel[1:0]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shot_sequencer.md
# shot_sequencer

Top-level game and shot controller that drives `path`. It owns the game state (`Game_State`) and launches, flies and retires the single shooter ball whose position feeds `path`'s collision check. It supplies the current ball colour and the LFSR-based `random_color` for path spawns, and retires the shot on `path`'s `inserted` pulse.

## Interface
Parameters:
- SHOT_Y0, 10'd440: launch Y of a fired ball.
- SHOT_Y_MIN, 10'd16: top boundary; at or above this the ball is a miss.
- SHOT_SPEED, 10'd8: pixels moved up per frame_clk.
- PARK_XY, 10'd1000: X and Y of the parked, non-flying ball; off-screen, never collides.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high.
- frame_clk  in  1  one-Clk pulse per video frame.
- start  in  1  level key; rising edge is used.
- fire  in  1  level key; rising edge is used.
- swap  in  1  level key; rising edge is used; only present with COLOR_SWAP_EN.
- Shooter_X  in  10  shooter barrel X.
- dead  in  1  from path.
- win  in  1  from path.
- inserted  in  1  from path; high during its Insert phase.
- Game_State  out  2  0 Idle, 1 Play, 2 Over, 3 Won.
- Shot_X  out  10  shot ball X, to path Shooted_pos_X.
- Shot_Y  out  10  shot ball Y, to path Shooted_pos_Y.
- Cur_Color  out  4  colour of the loaded or flying ball (1..4), to path Color_in.
- Next_Color  out  4  preview colour (1..4).
- random_color  out  2  LFSR[1:0], to path.
- shot_active  out  1  ball is flying.
- Shots_Fired  out  8  saturating count of shots this game.

## Operation
Game FSM (encoding equals Game_State):
- Idle: start edge goes to Play.
- Play: `dead` goes to Over. Otherwise `win` goes to Won. `dead` has priority when both are high in the same cycle.
- Over and Won: start edge goes to Idle.
- Entering Play:
  - Cur_Color ← LFSR[1:0]+1 and Next_Color ← LFSR[3:2]+1, sampled in the transition cycle.
  - Shots_Fired ← 0.
  - Shot FSM ← Loaded.

Shot FSM (active only in Play; forced to Loaded with the ball parked in every other game state):
- Loaded:
  - Ball parked; shot_active=0.
  - fire edge: Shot_X ← Shooter_X, Shot_Y ← SHOT_Y0, Shots_Fired += 1 (saturate at 255), go to Flying.
- Flying:
  - shot_active=1.
  - On frame_clk: if Shot_Y < SHOT_Y_MIN + SHOT_SPEED, go to Retire (miss); else Shot_Y ← Shot_Y − SHOT_SPEED.
  - On inserted (first high cycle seen while Flying): go to Retire (hit). A hit takes priority over a frame_clk move in the same cycle.
  - fire edges are ignored.
- Retire:
  - Ball parked.
  - Cur_Color ← Next_Color; Next_Color ← LFSR[1:0]+1.
  - Go to Wait_Clear.
- Wait_Clear:
  - Hold until inserted is low, then go to Loaded.
  - This prevents a multi-cycle inserted from retiring the next shot.

LFSR:
- 16-bit Fibonacci, taps 16,14,13,11.
- Shifts every Clk in all states; reset to LFSR_SEED.
- random_color = LFSR[1:0].

Edge detectors: one registered copy each of start, fire and swap. An edge is current & ~previous.

## Timing
- Reset values:
  - Game_State=0; shot FSM Loaded.
  - Shot_X=Shot_Y=PARK_XY.
  - Cur_Color=1, Next_Color=2.
  - shot_active=0, Shots_Fired=0.
  - LFSR=LFSR_SEED, so random_color=LFSR_SEED[1:0]=1.
  - Edge registers 0.
- All outputs are registered.
- start edge to Game_State change: 1 Clk after the edge cycle.
- fire edge to Shot_X/Shot_Y loaded and shot_active=1: 1 Clk.
- Position update: Shot_Y changes in the Clk after the frame_clk cycle.
- Hit: inserted high in cycle N gives ball parked and colours rotated at N+2 (Flying→Retire at N+1, Retire outputs at N+2).
- Game state changes to Over or Won while Flying: the ball parks on the same edge as the state change.
- Reset mid-flight: all values return to reset values on the next edge.
- Shot_Y arithmetic is 10-bit unsigned. The miss test runs before the subtraction, so Shot_Y never wraps.

## Configuration
- COLOR_SWAP_EN defined:
  - `swap` port exists.
  - A swap edge in Play with the shot FSM in Loaded exchanges Cur_Color and Next_Color in 1 Clk.
  - A swap edge in any other state is ignored.
- COLOR_SWAP_EN undefined:
  - No `swap` port.
  - Colours change only on Retire and on entry to Play.

## Test plan
- Reset, then start pulse → Game_State=1 one Clk later, Shots_Fired=0, Shot_X=Shot_Y=1000.
- Fire with Shooter_X=300 → Shot_X=300, Shot_Y=440, shot_active=1; after 3 frame_clk pulses, Shot_Y=416.
- Flying, inserted held 5 cycles → exactly one retire: Cur_Color takes the old Next_Color, ball parked, Shots_Fired=1. A fire edge during inserted-high is not launched.
- No hit: Shot_Y steps 440→24 in 52 frames; the next frame_clk (Shot_Y=24 < 24 is false → 16; next 16<24) retires at Shot_Y=16 without wrapping. Verify shot_active drops.
- dead and win high in the same cycle while Flying → Game_State=2, ball parked; a start edge then gives Game_State=0.
- With COLOR_SWAP_EN, Cur=3 and Next=1, swap edge while Loaded → Cur=1, Next=3. A swap edge while Flying → colours unchanged.
